hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and control unit; the producer of the 2-bit mode_i consumed by every pipeline register (PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB).
- Resolves the following per cycle and emits one Normal/Stall/Flush mode per register:
  - data-memory wait;
  - multicycle EXE ops (div/rem), using an internal latency counter;
  - taken-branch redirect;
  - load-use hazards.
- Also counts stall cycles for performance monitoring.

Parameters:
MC_LATENCY, 32, cycles a multicycle EXE op occupies EXE (legal range 2..255)
CNT_WIDTH, 32, width of stall_cnt_o (saturating)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_rs1_addr_i  in  GPR_ADDR_SPACE  ID-stage rs1 address
id_rs1_re_i  in  1  ID reads rs1
id_rs2_addr_i  in  GPR_ADDR_SPACE  ID-stage rs2 address
id_rs2_re_i  in  1  ID reads rs2
ex_rd_addr_i  in  GPR_ADDR_SPACE  rd of instruction in EXE (ID_EXE output)
ex_rd_we_i  in  1  EXE instruction writes rd
ex_mem_re_i  in  1  EXE instruction is a load
ex_branch_taken_i  in  1  EXE resolved taken branch/jump
ex_mc_op_i  in  1  EXE instruction is multicycle
dmem_busy_i  in  1  MEM-stage access not complete this cycle
pc_mode_o  out  2  mode for PC register
if_id_mode_o  out  2  mode for IF_ID
id_exe_mode_o  out  2  mode for ID_EXE
exe_mem_mode_o  out  2  mode for EXE_MEM
mem_wb_mode_o  out  2  mode for MEM_WB
mc_done_o  out  1  pulse: multicycle result valid this cycle
stall_cnt_o  out  CNT_WIDTH  cycles with pc_mode_o == Stall

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_i is synchronous, active-high.
- Mode outputs:
  - Combinational from state and inputs; registers sample them at the same posedge.
  - Any mode not listed for a case is Normal.
- Reset:
  - While rst_i is high, all five modes are Flush.
  - mc_done_o=0.
  - State <= RUN, mc counter <= 0, stall_cnt_o <= 0.
  - Reset mid multicycle op or mid memory wait aborts it; no pending state survives.
- States: RUN, MC_BUSY, MEM_WAIT.
- Priority, highest first, evaluated every cycle:
  1. dmem_busy_i=1:
     - pc, if_id, id_exe, exe_mem = Stall; mem_wb = Flush.
     - State MEM_WAIT; the mc counter is frozen.
     - Exit the same cycle busy drops; return to the prior state (RUN or MC_BUSY) saved on entry.
  2. MC_BUSY, counter != 1:
     - pc, if_id, id_exe = Stall; exe_mem = Flush.
     - Counter decrements.
  3. MC_BUSY, counter == 1:
     - mc_done_o=1; all modes Normal, so the result advances.
     - State <= RUN, counter <= 0.
  4. RUN and ex_mc_op_i=1:
     - Load counter with MC_LATENCY-1; state <= MC_BUSY.
     - Modes as case 2 (this counts as the first busy cycle).
     - Total residency in EXE is MC_LATENCY cycles, with mc_done_o in the last one.
     - Because the op advances on its done cycle, ex_mc_op_i still high in that cycle must not restart the FSM.
  5. ex_branch_taken_i=1:
     - if_id = Flush, id_exe = Flush; pc = Normal (loads target).
     - A simultaneous load-use is ignored, since the ID instruction is wrong-path.
  6. Load-use:
     - Condition: ex_mem_re_i & ex_rd_we_i & ex_rd_addr_i != 0 & ((id_rs1_re_i & id_rs1_addr_i == ex_rd_addr_i) | (id_rs2_re_i & id_rs2_addr_i == ex_rd_addr_i)).
     - pc, if_id = Stall; id_exe = Flush (one bubble).
     - No state change; the hazard clears next cycle because the load has advanced.
  7. Otherwise all modes are Normal.
- Branch during stall:
  - A taken branch during MEM_WAIT or MC_BUSY is held in EXE by the Stall.
  - ex_branch_taken_i therefore persists and is applied once EXE is released.
  - No latch is required.
- stall_cnt_o:
  - Increments on each non-reset cycle in which pc_mode_o == Stall.
  - Saturates at all-ones and never wraps.

Decomposition:
- Shared defines file (existing) holds the mode encodings:
  - Normal 2'b00, Stall 2'b01, Flush 2'b10; 2'b11 is reserved and treated as Normal by consumers.
  - It also holds GPR_ADDR_SPACE and the state encodings RUN=0, MC_BUSY=1, MEM_WAIT=2.
- One natural sub-module, hazard_mc_counter: the load/decrement/freeze counter with its done flag.
- Priority logic and stall_cnt stay in the top module.

Test Plan:
- Reset: hold rst_i 2 cycles -> all modes = 2'b10, stall_cnt_o=0, mc_done_o=0; release -> all modes Normal.
- Load-use: ex_mem_re_i=1, ex_rd_we_i=1, ex_rd_addr_i=5, id_rs2_re_i=1, id_rs2_addr_i=5 -> pc/if_id=Stall, id_exe=Flush for 1 cycle, stall_cnt_o=1; same with ex_rd_addr_i=0 -> no stall.
- Branch vs load-use: load-use condition and ex_branch_taken_i=1 together -> if_id=Flush, id_exe=Flush, pc=Normal, stall_cnt_o unchanged.
- Multicycle: MC_LATENCY=4, ex_mc_op_i held high -> 3 cycles of id_exe=Stall/exe_mem=Flush, then 1 cycle mc_done_o=1 with all Normal; stall_cnt_o=3; no restart on the done cycle.
- Memory wait inside multicycle: MC_LATENCY=4, assert dmem_busy_i for 2 cycles starting at the 2nd busy cycle -> mem_wb=Flush for those 2 cycles, counter frozen, mc_done_o arrives in cycle 6.
- Saturation and reset abort:
  - CNT_WIDTH=3, 10 stall cycles -> stall_cnt_o stays 7.
  - rst_i mid MC_BUSY -> next cycle after release is RUN; mc_done_o never pulses for the aborted op.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/control unit: register modes, FSM states
// and the GPR address width.
package hazard_ctrl_pkg;

  localparam int GPR_ADDR_SPACE = 5;
  localparam int MC_CNT_W       = 8;

  // 2'b11 is reserved; consumers treat it as Normal.
  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_STALL  = 2'b01,
    MODE_FLUSH  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_mc_counter.sv
// Latency counter for multicycle EXE ops: load, decrement or freeze;
// done_o flags the final residency cycle (count == 1).
module hazard_mc_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic done_o
);

  localparam logic [MC_CNT_W-1:0] LOAD_VAL = MC_CNT_W'(MC_LATENCY - 1);

  logic [MC_CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_reg <= '0;
    end else if (load_i) begin
      cnt_reg <= LOAD_VAL;
    end else if (dec_i) begin
      cnt_reg <= cnt_reg - MC_CNT_W'(1);
    end
  end

  assign done_o = (cnt_reg == MC_CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: resolves memory wait, multicycle EXE,
// taken branches and load-use per cycle into per-register Normal/Stall/Flush modes.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [GPR_ADDR_SPACE-1:0] id_rs1_addr_i,
  input  logic                      id_rs1_re_i,
  input  logic [GPR_ADDR_SPACE-1:0] id_rs2_addr_i,
  input  logic                      id_rs2_re_i,
  input  logic [GPR_ADDR_SPACE-1:0] ex_rd_addr_i,
  input  logic                      ex_rd_we_i,
  input  logic                      ex_mem_re_i,
  input  logic                      ex_branch_taken_i,
  input  logic                      ex_mc_op_i,
  input  logic                      dmem_busy_i,
  output logic [1:0]                pc_mode_o,
  output logic [1:0]                if_id_mode_o,
  output logic [1:0]                id_exe_mode_o,
  output logic [1:0]                exe_mem_mode_o,
  output logic [1:0]                mem_wb_mode_o,
  output logic                      mc_done_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  hz_state_t state_reg, state_next;
  hz_state_t saved_reg, saved_next;
  hz_state_t eff_state;

  mode_t pc_mode, if_id_mode, id_exe_mode, exe_mem_mode, mem_wb_mode;
  logic  mc_done;
  logic  cnt_load, cnt_dec, cnt_clr, cnt_done;
  logic  load_use;

  logic [GPR_ADDR_SPACE-1:0] src_addr [2];
  logic [1:0]                src_re;
  logic [1:0]                src_hit;

  logic [CNT_WIDTH-1:0] stall_cnt_reg;

  assign src_addr[0] = id_rs1_addr_i;
  assign src_addr[1] = id_rs2_addr_i;
  assign src_re      = {id_rs2_re_i, id_rs1_re_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_re[gi] && (src_addr[gi] == ex_rd_addr_i);
  end

  assign load_use = ex_mem_re_i && ex_rd_we_i && (ex_rd_addr_i != '0) && (|src_hit);

  // MEM_WAIT is transparent once busy drops: act as the state saved on entry.
  assign eff_state = (state_reg == MEM_WAIT) ? saved_reg : state_reg;

  hazard_mc_counter #(
    .MC_LATENCY(MC_LATENCY)
  ) u_mc_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(cnt_load),
    .dec_i (cnt_dec),
    .clr_i (cnt_clr),
    .done_o(cnt_done)
  );

  always_comb begin
    pc_mode      = MODE_NORMAL;
    if_id_mode   = MODE_NORMAL;
    id_exe_mode  = MODE_NORMAL;
    exe_mem_mode = MODE_NORMAL;
    mem_wb_mode  = MODE_NORMAL;
    mc_done      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_clr      = 1'b0;
    state_next   = eff_state;
    saved_next   = saved_reg;
    if (rst_i) begin
      pc_mode      = MODE_FLUSH;
      if_id_mode   = MODE_FLUSH;
      id_exe_mode  = MODE_FLUSH;
      exe_mem_mode = MODE_FLUSH;
      mem_wb_mode  = MODE_FLUSH;
    end else if (dmem_busy_i) begin
      pc_mode      = MODE_STALL;
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_STALL;
      exe_mem_mode = MODE_STALL;
      mem_wb_mode  = MODE_FLUSH;
      state_next   = MEM_WAIT;
      saved_next   = eff_state;
    end else if (eff_state == MC_BUSY && !cnt_done) begin
      pc_mode      = MODE_STALL;
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_STALL;
      exe_mem_mode = MODE_FLUSH;
      cnt_dec      = 1'b1;
    end else if (eff_state == MC_BUSY) begin
      // Done cycle: the op advances, so ex_mc_op_i here belongs to it.
      mc_done    = 1'b1;
      cnt_clr    = 1'b1;
      state_next = RUN;
    end else if (ex_mc_op_i) begin
      pc_mode      = MODE_STALL;
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_STALL;
      exe_mem_mode = MODE_FLUSH;
      cnt_load     = 1'b1;
      state_next   = MC_BUSY;
    end else if (ex_branch_taken_i) begin
      if_id_mode  = MODE_FLUSH;
      id_exe_mode = MODE_FLUSH;
    end else if (load_use) begin
      pc_mode     = MODE_STALL;
      if_id_mode  = MODE_STALL;
      id_exe_mode = MODE_FLUSH;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= RUN;
      saved_reg     <= RUN;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      if (pc_mode == MODE_STALL && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign pc_mode_o      = pc_mode;
  assign if_id_mode_o   = if_id_mode;
  assign id_exe_mode_o  = id_exe_mode;
  assign exe_mem_mode_o = exe_mem_mode;
  assign mem_wb_mode_o  = mem_wb_mode;
  assign mc_done_o      = mc_done;
  assign stall_cnt_o    = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multicycle
// sequences and randomized traffic against a residency-based reference model.
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [1:0] N = 2'b00, S = 2'b01, F = 2'b10;

  typedef struct {
    logic       rst;
    logic [4:0] rs1; logic rs1_re;
    logic [4:0] rs2; logic rs2_re;
    logic [4:0] rd;  logic rd_we;
    logic       mem_re, br, mc, busy;
  } in_t;

  typedef struct {
    logic [1:0] pc, ifid, idexe, exemem, memwb;
    logic       done;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } tv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i, id_rs1_re_i, id_rs2_re_i, ex_rd_we_i, ex_mem_re_i;
  logic       ex_branch_taken_i, ex_mc_op_i, dmem_busy_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic [1:0] pc_mode_o, if_id_mode_o, id_exe_mode_o, exe_mem_mode_o, mem_wb_mode_o;
  logic       mc_done_o;
  logic [CW-1:0] stall_cnt_o;

  hazard_ctrl #(.MC_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_re_i(id_rs1_re_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_re_i(id_rs2_re_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i),
    .ex_mem_re_i(ex_mem_re_i), .ex_branch_taken_i(ex_branch_taken_i),
    .ex_mc_op_i(ex_mc_op_i), .dmem_busy_i(dmem_busy_i),
    .pc_mode_o(pc_mode_o), .if_id_mode_o(if_id_mode_o),
    .id_exe_mode_o(id_exe_mode_o), .exe_mem_mode_o(exe_mem_mode_o),
    .mem_wb_mode_o(mem_wb_mode_o), .mc_done_o(mc_done_o),
    .stall_cnt_o(stall_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: an op in flight and how many EXE cycles it still needs.
  bit m_active = 1'b0;
  int m_left   = 0;
  int m_cnt    = 0;

  function automatic in_t mk_in(logic [4:0] rs1, logic rs1_re, logic [4:0] rs2,
                                logic rs2_re, logic [4:0] rd, logic we,
                                logic mre, logic br, logic mc, logic busy);
    in_t v;
    v.rst = 1'b0; v.rs1 = rs1; v.rs1_re = rs1_re; v.rs2 = rs2; v.rs2_re = rs2_re;
    v.rd = rd; v.rd_we = we; v.mem_re = mre; v.br = br; v.mc = mc; v.busy = busy;
    return v;
  endfunction

  function automatic out_t mk_out(logic [1:0] pc, logic [1:0] ifid, logic [1:0] idexe,
                                  logic [1:0] exemem, logic [1:0] memwb, logic done);
    out_t o;
    o.pc = pc; o.ifid = ifid; o.idexe = idexe; o.exemem = exemem; o.memwb = memwb;
    o.done = done;
    return o;
  endfunction

  function automatic bit is_load_use(in_t v);
    return v.mem_re && v.rd_we && (v.rd != 0) &&
           ((v.rs1_re && v.rs1 == v.rd) || (v.rs2_re && v.rs2 == v.rd));
  endfunction

  function automatic out_t model_out(in_t v);
    if (v.rst)                    return mk_out(F, F, F, F, F, 0);
    if (v.busy)                   return mk_out(S, S, S, S, F, 0);
    if (m_active && m_left > 1)   return mk_out(S, S, S, F, N, 0);
    if (m_active)                 return mk_out(N, N, N, N, N, 1);
    if (v.mc)                     return mk_out(S, S, S, F, N, 0);
    if (v.br)                     return mk_out(N, F, F, N, N, 0);
    if (is_load_use(v))           return mk_out(S, S, F, N, N, 0);
    return mk_out(N, N, N, N, N, 0);
  endfunction

  task automatic model_update(in_t v, out_t o);
    if (v.rst) begin
      m_active = 1'b0; m_left = 0; m_cnt = 0;
    end else begin
      if (o.pc == S && m_cnt < SAT) m_cnt++;
      if (!v.busy) begin
        if (m_active) begin
          if (m_left > 1) m_left--;
          else m_active = 1'b0;
        end else if (v.mc) begin
          m_active = 1'b1; m_left = LAT - 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(in_t v);
    rst_i = v.rst;
    id_rs1_addr_i = v.rs1; id_rs1_re_i = v.rs1_re;
    id_rs2_addr_i = v.rs2; id_rs2_re_i = v.rs2_re;
    ex_rd_addr_i = v.rd; ex_rd_we_i = v.rd_we; ex_mem_re_i = v.mem_re;
    ex_branch_taken_i = v.br; ex_mc_op_i = v.mc; dmem_busy_i = v.busy;
  endtask

  // One cycle: drive at negedge, check just after, advance model at posedge.
  task automatic step(input in_t v, input bit use_tbl, input out_t te, input string tag);
    out_t e;
    drive(v);
    #1;
    e = model_out(v);
    if (use_tbl) e = te;
    chk({tag, "_pc"},     int'(pc_mode_o),      int'(e.pc));
    chk({tag, "_ifid"},   int'(if_id_mode_o),   int'(e.ifid));
    chk({tag, "_idexe"},  int'(id_exe_mode_o),  int'(e.idexe));
    chk({tag, "_exemem"}, int'(exe_mem_mode_o), int'(e.exemem));
    chk({tag, "_memwb"},  int'(mem_wb_mode_o),  int'(e.memwb));
    chk({tag, "_done"},   int'(mc_done_o),      int'(e.done));
    chk({tag, "_scnt"},   int'(stall_cnt_o),    m_cnt);
    $display("cyc %s rst=%0b busy=%0b mc=%0b br=%0b lu=%0b -> pc=%0d ifid=%0d idexe=%0d exemem=%0d memwb=%0d done=%0b scnt=%0d",
             tag, v.rst, v.busy, v.mc, v.br, is_load_use(v), pc_mode_o, if_id_mode_o,
             id_exe_mode_o, exe_mem_mode_o, mem_wb_mode_o, mc_done_o, stall_cnt_o);
    @(posedge clk);
    model_update(v, model_out(v));
    @(negedge clk);
  endtask

  task automatic run(input in_t v, input string tag);
    step(v, 1'b0, mk_out(N, N, N, N, N, 0), tag);
  endtask

  task automatic do_reset(input int cycles);
    in_t r;
    r = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r.rst = 1'b1;
    for (int i = 0; i < cycles; i++) run(r, "reset");
  endtask

  tv_t  tbl [10];
  in_t  idle, lu, mcv, mcb, rnd;

  initial begin
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk_in(0, 0, 5, 1, 5, 1, 1, 0, 0, 0);
    mcv  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    mcb  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    tbl[0] = '{in: idle,                                    exp: mk_out(N, N, N, N, N, 0)};
    tbl[1] = '{in: lu,                                      exp: mk_out(S, S, F, N, N, 0)};
    tbl[2] = '{in: mk_in(7, 1, 0, 0, 7, 1, 1, 0, 0, 0),      exp: mk_out(S, S, F, N, N, 0)};
    tbl[3] = '{in: mk_in(0, 1, 0, 1, 0, 1, 1, 0, 0, 0),      exp: mk_out(N, N, N, N, N, 0)};
    tbl[4] = '{in: mk_in(0, 0, 5, 0, 5, 1, 1, 0, 0, 0),      exp: mk_out(N, N, N, N, N, 0)};
    tbl[5] = '{in: mk_in(0, 0, 5, 1, 5, 1, 0, 0, 0, 0),      exp: mk_out(N, N, N, N, N, 0)};
    tbl[6] = '{in: mk_in(0, 0, 5, 1, 5, 0, 1, 0, 0, 0),      exp: mk_out(N, N, N, N, N, 0)};
    tbl[7] = '{in: mk_in(0, 0, 5, 1, 5, 1, 1, 1, 0, 0),      exp: mk_out(N, F, F, N, N, 0)};
    tbl[8] = '{in: mk_in(0, 0, 5, 1, 5, 1, 1, 0, 0, 1),      exp: mk_out(S, S, S, S, F, 0)};
    tbl[9] = '{in: idle,                                    exp: mk_out(N, N, N, N, N, 0)};

    // Bring the DUT out of power-up unknowns before any checking.
    drive(idle);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles, then release.
    do_reset(2);
    chk("rst_scnt", int'(stall_cnt_o), 0);
    run(idle, "post_rst");

    // Single-cycle vector table from RUN.
    do_reset(1);
    for (int i = 0; i < 10; i++) step(tbl[i].in, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
    chk("tbl_scnt", int'(stall_cnt_o), 3);

    // Multicycle op with ex_mc_op_i held through its done cycle.
    do_reset(1);
    for (int i = 0; i < LAT; i++) run(mcv, $sformatf("mc%0d", i));
    chk("mc_scnt", int'(stall_cnt_o), LAT - 1);
    run(idle, "mc_after");

    // Memory wait during the 2nd and 3rd cycles of a multicycle op.
    do_reset(1);
    run(mcv, "mw1");
    run(mcb, "mw2");
    run(mcb, "mw3");
    run(mcv, "mw4");
    run(mcv, "mw5");
    drive(mcv);
    #1;
    chk("mw6_done", int'(mc_done_o), 1);
    @(negedge clk);
    model_update(mcv, model_out(mcv));
    run(idle, "mw7");

    // Stall counter saturation.
    do_reset(1);
    for (int i = 0; i < 10; i++) run(lu, $sformatf("sat%0d", i));
    chk("sat_scnt", int'(stall_cnt_o), SAT);

    // Reset aborting a multicycle op.
    do_reset(1);
    run(mcv, "ab1");
    run(mcv, "ab2");
    do_reset(1);
    for (int i = 0; i < LAT + 2; i++) run(idle, $sformatf("ab_idle%0d", i));

    // Randomized traffic against the model.
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      rnd = mk_in(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
      rnd.rst = 1'($urandom_range(0, 39) == 0);
      run(rnd, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
